// File: rtl/edge_pixel_packer_pkg.sv
// Shared types and helpers for the edge pixel packer.
// Optional binarization is enabled by defining EDGE_PACK_THRESH_EN.
package edge_pixel_packer_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_IMAGE_WIDTH  = 720;
    localparam int DEF_IMAGE_HEIGHT = 540;
    localparam int DEF_PACK_PIXELS  = 4;

    function automatic int pix_per_frame(input int width, input int height);
        return width * height;
    endfunction

    // Unsigned compare; caller replicates the flag across the lane.
    function automatic logic binarize(input logic [31:0] pix,
                                      input logic [31:0] thr);
        return pix >= thr;
    endfunction

endpackage

// File: rtl/edge_pixel_packer_if.sv
// FIFO-side handshake bundle of the edge pixel packer.
// master: packer side; slave: surrounding FIFOs / environment.
interface edge_pixel_packer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int PACK_PIXELS = 4
);
    logic                              in_empty;
    logic [DATA_WIDTH-1:0]             in_data;
    logic                              in_rd_en;
    logic                              out_full;
    logic                              out_wr_en;
    logic [PACK_PIXELS*DATA_WIDTH-1:0] out_data;
    logic                              out_last;

    modport master (
        input  in_empty,
        input  in_data,
        input  out_full,
        output in_rd_en,
        output out_wr_en,
        output out_data,
        output out_last
    );

    modport slave (
        output in_empty,
        output in_data,
        output out_full,
        input  in_rd_en,
        input  out_wr_en,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/edge_pixel_packer.sv
// Packs edge pixels LSB-first into wide words, flushing a padded word at end of frame.
// Define EDGE_PACK_THRESH_EN to store binarized pixels instead of raw values.
module edge_pixel_packer
    import edge_pixel_packer_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int PACK_PIXELS  = DEF_PACK_PIXELS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] threshold,
    edge_pixel_packer_if.master   bus,
    output logic                  frame_done,
    output logic [15:0]           frame_count
);

    localparam int PIX = pix_per_frame(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int CW  = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int LW  = $clog2(PACK_PIXELS);

    localparam logic [CW-1:0] LAST_PIX  = CW'(PIX - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(PACK_PIXELS - 1);

    state_t                                   state;
    logic [LW-1:0]                            lane_idx;
    logic [CW-1:0]                            pix_cnt;
    logic [PACK_PIXELS-1:0][DATA_WIDTH-1:0]   lanes;
    logic                                     eof;
    logic                                     pop;
    logic                                     push;
    logic [DATA_WIDTH-1:0]                    pix_val;

`ifdef EDGE_PACK_THRESH_EN
    assign pix_val = {DATA_WIDTH{binarize(32'(bus.in_data), 32'(threshold))}};
`else
    logic unused_threshold;
    assign unused_threshold = ^threshold;
    assign pix_val = bus.in_data;
`endif

    // Handshakes are masked in reset so nothing moves in the reset cycle.
    assign pop  = (state == FILL)  && !bus.in_empty && !rst;
    assign push = (state == WRITE) && !bus.out_full && !rst;

    assign bus.in_rd_en  = pop;
    assign bus.out_wr_en = push;
    assign bus.out_data  = lanes;
    assign bus.out_last  = (state == WRITE) && eof;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            lane_idx    <= '0;
            pix_cnt     <= '0;
            lanes       <= '0;
            eof         <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                FILL: begin
                    if (pop) begin
                        lanes[lane_idx] <= pix_val;
                        lane_idx        <= lane_idx + 1'b1;
                        if (pix_cnt == LAST_PIX) begin
                            eof   <= 1'b1;
                            state <= WRITE;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                            if (lane_idx == LAST_LANE)
                                state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (push) begin
                        lanes    <= '0;
                        lane_idx <= '0;
                        eof      <= 1'b0;
                        state    <= FILL;
                        // Frame position restarts only once the last word leaves.
                        if (eof) begin
                            pix_cnt     <= '0;
                            frame_count <= frame_count + 1'b1;
                            frame_done  <= 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_pixel_packer.sv
// Directed bench for edge_pixel_packer: reset, packing, flush, stalls, gaps, reset mid-word.
// Expectation for the binarize case follows EDGE_PACK_THRESH_EN as compiled.
module tb_edge_pixel_packer;
    import edge_pixel_packer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] threshold;
    logic fd_a, fd_b;
    logic [15:0] fc_a, fc_b;

    always #5 clk = ~clk;

    edge_pixel_packer_if #(.DATA_WIDTH(8), .PACK_PIXELS(4)) ifa ();
    edge_pixel_packer_if #(.DATA_WIDTH(8), .PACK_PIXELS(4)) ifb ();

    edge_pixel_packer #(
        .DATA_WIDTH(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .PACK_PIXELS(4)
    ) dut_a (
        .clk(clk), .rst(rst), .threshold(threshold), .bus(ifa.master),
        .frame_done(fd_a), .frame_count(fc_a)
    );

    edge_pixel_packer #(
        .DATA_WIDTH(8), .IMAGE_WIDTH(3), .IMAGE_HEIGHT(1), .PACK_PIXELS(4)
    ) dut_b (
        .clk(clk), .rst(rst), .threshold(threshold), .bus(ifb.master),
        .frame_done(fd_b), .frame_count(fc_b)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  q[$];
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          fd_cnt;
    bit          gaps;
    logic        last_rd, last_wr, last_fd;
    logic [31:0] last_dat;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic feed();
        ifa.in_empty = (q.size() == 0) || (gaps && $urandom_range(0, 2) == 0);
        ifa.in_data  = (q.size() > 0) ? q[0] : 8'h00;
    endtask

    task automatic tick();
        @(negedge clk);
        last_rd  = ifa.in_rd_en;
        last_wr  = ifa.out_wr_en;
        last_dat = ifa.out_data;
        last_fd  = fd_a;
        if (ifa.out_wr_en) begin
            got_d.push_back(ifa.out_data);
            got_l.push_back(ifa.out_last);
        end
        if (fd_a) fd_cnt++;
        @(posedge clk);
        #1;
        if (last_rd && q.size() > 0) void'(q.pop_front());
        feed();
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        fd_cnt = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        q.delete();
        feed();
        repeat (n) tick();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic wait_words(input int n, input int budget);
        int b = 0;
        while (got_d.size() < n && b < budget) begin
            tick();
            b++;
        end
        check("word_timeout", 64'(got_d.size() >= n), 64'd1);
    endtask

    task automatic load_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) q.push_back(first + 8'(i));
        feed();
    endtask

    task automatic wait_pops(input int n);
        int pops = 0;
        int b = 0;
        while (pops < n && b < 50) begin
            tick();
            if (last_rd) pops++;
            b++;
        end
        check("pop_timeout", 64'(pops), 64'(n));
    endtask

    logic [7:0]  pb[4];
    int          ib, bb;
    logic        rdb, seen_b, lb;
    logic [31:0] wb;

    initial begin
        rst = 1'b1;
        gaps = 1'b0;
        threshold = 8'h80;
        fd_cnt = 0;
        ifa.out_full = 1'b0;
        ifb.out_full = 1'b0;
        ifb.in_empty = 1'b1;
        ifb.in_data  = 8'h00;

        // 1: reset held with data available
        load_seq(8'h01, 8);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rd_en", 64'(last_rd), 64'd0);
            check("rst_wr_en", 64'(last_wr), 64'd0);
            check("rst_fcount", 64'(fc_a), 64'd0);
            check("rst_data", 64'(last_dat), 64'd0);
            check("rst_fdone", 64'(last_fd), 64'd0);
        end
        rst = 1'b0;
        clear_log();

        // 2: one full frame, two words
        wait_words(2, 50);
        repeat (3) tick();
        check("c2_w0", 64'(got_d[0]), 64'h04030201);
        check("c2_l0", 64'(got_l[0]), 64'd0);
        check("c2_w1", 64'(got_d[1]), 64'h08070605);
        check("c2_l1", 64'(got_l[1]), 64'd1);
        check("c2_fdone", 64'(fd_cnt), 64'd1);
        check("c2_fcount", 64'(fc_a), 64'd1);

        // 4: downstream full during the first write
        clear_log();
        ifa.out_full = 1'b1;
        load_seq(8'h01, 8);
        wait_pops(4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("c4_hold_data", 64'(last_dat), 64'h04030201);
            check("c4_hold_rd", 64'(last_rd), 64'd0);
            check("c4_hold_wr", 64'(last_wr), 64'd0);
        end
        ifa.out_full = 1'b0;
        wait_words(2, 50);
        repeat (3) tick();
        check("c4_w0", 64'(got_d[0]), 64'h04030201);
        check("c4_l0", 64'(got_l[0]), 64'd0);
        check("c4_w1", 64'(got_d[1]), 64'h08070605);
        check("c4_l1", 64'(got_l[1]), 64'd1);
        check("c4_fcount", 64'(fc_a), 64'd2);

        // 5: three frames with random upstream gaps
        do_reset(2);
        gaps = 1'b1;
        for (int f = 0; f < 3; f++) load_seq(8'h01, 8);
        wait_words(6, 400);
        gaps = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            check("c5_word", 64'(got_d[i]),
                  (i % 2) ? 64'h08070605 : 64'h04030201);
            check("c5_last", 64'(got_l[i]), 64'(i % 2));
        end
        check("c5_fdone", 64'(fd_cnt), 64'd3);
        check("c5_fcount", 64'(fc_a), 64'd3);

        // 6: threshold behaviour
        do_reset(1);
        threshold = 8'h80;
        q.push_back(8'h7F);
        q.push_back(8'h80);
        q.push_back(8'hFF);
        q.push_back(8'h00);
        load_seq(8'h00, 4);
        wait_words(1, 50);
`ifdef EDGE_PACK_THRESH_EN
        check("c6_bin", 64'(got_d[0]), 64'h00FFFF00);
`else
        check("c6_raw", 64'(got_d[0]), 64'h00FF807F);
`endif

        // 7: reset after two pops drops the partial word
        do_reset(1);
        load_seq(8'hEE, 8);
        wait_pops(2);
        do_reset(1);
        load_seq(8'h11, 8);
        wait_words(1, 50);
        check("c7_w0", 64'(got_d[0]), 64'h14131211);
        check("c7_l0", 64'(got_l[0]), 64'd0);

        // 3: 3x1 frame flushes a single padded word
        pb[0] = 8'hA1;
        pb[1] = 8'hA2;
        pb[2] = 8'hA3;
        pb[3] = 8'h00;
        ib = 0;
        bb = 0;
        seen_b = 1'b0;
        wb = '0;
        lb = 1'b0;
        ifb.in_empty = 1'b0;
        ifb.in_data  = pb[0];
        while (!seen_b && bb < 30) begin
            @(negedge clk);
            if (ifb.out_wr_en) begin
                wb = ifb.out_data;
                lb = ifb.out_last;
                seen_b = 1'b1;
            end
            rdb = ifb.in_rd_en;
            @(posedge clk);
            #1;
            if (rdb) ib++;
            ifb.in_empty = (ib >= 3);
            ifb.in_data  = pb[ib];
            bb++;
        end
        @(negedge clk);
        check("c3_seen", 64'(seen_b), 64'd1);
        check("c3_word", 64'(wb), 64'h00A3A2A1);
        check("c3_last", 64'(lb), 64'd1);
        check("c3_fcount", 64'(fc_b), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
